nearest_center_search: RTL and testbench
========================================

// Module: nearest_center_search
// PURPOSE
//  Sequential consumer of the Manhattan-distance datapath. Accepts one point on a
//  valid/ready port and scans it against k stored centers, one per cycle, through
//  a registered |a-b| distance stage. Returns the index and distance of the nearest
//  center on a valid/ready result port. Serves as the flat (non-tree) assignment
//  engine for kmeans, and as the golden comparator for the kd-tree search.
// PARAMETERS
//  dim         3    coordinates per point (datapath fixed at 3: x,y,z)
//  data_range  255  max coordinate; dim_size=$clog2(data_range), dist_size=$clog2(data_range*dim)
//  k           8    number of centers (>=2); idx_size=$clog2(k); center_size=dim*dim_size
// PORTS
//  clk        in   1            clock, all state on rising edge
//  rst        in   1            asynchronous, active-high reset
//  ctr_we     in   1            center write strobe (honoured only in IDLE)
//  ctr_waddr  in   idx_size     center index to write (>=k ignored)
//  ctr_wdata  in   center_size  center {z,y,x}, x in [dim_size-1:0]
//  pt_valid   in   1            point offered
//  pt_ready   out  1            block idle, will accept point
//  pt_data    in   center_size  point {z,y,x}
//  res_valid  out  1            result held
//  res_ready  in   1            downstream accepts result
//  res_idx    out  idx_size     index of nearest center
//  res_dist   out  dist_size    Manhattan distance to it
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all centers=0, res_valid/res_idx/res_dist/busy=0; pt_ready=0 while rst high.
//  FSM IDLE->SCAN->DRAIN->OUT->IDLE. pt_ready=(state==IDLE); no other state accepts.
//  IDLE: pt_valid&&pt_ready at edge E0 latches pt_data, cnt<=0, ->SCAN. ctr_we writes here only.
//  SCAN: each cycle dist=|px-cx|+|py-cy|+|pz-cz| for center[cnt]; |a-b| computed as
//   (a>=b)?a-b:b-a on unsigned dim_size values (no wrap); sum zero-extended to dist_size,
//   never overflows (max 765). Registered with cnt into (d_q,i_q,v_q). cnt==k-1 -> DRAIN.
//  Compare stage (every edge with v_q=1): if i_q==0 or d_q<best_dist then best<=(d_q,i_q).
//   Strict less-than: ties keep lowest index.
//  DRAIN: one cycle; last distance compared; res_idx/res_dist<=best, res_valid<=1, ->OUT.
//  Latency: res_valid rises k+1 edges after E0 (E(k+1)); 9 for k=8.
//  OUT: res_valid, res_idx, res_dist stable until res_valid&&res_ready; at that edge
//   res_valid<=0, ->IDLE. res_idx/res_dist keep last value afterwards.
//  ctr_we while busy: ignored, centers unchanged. ctr_waddr>=k: ignored.
//  Reset mid-operation: abort, no result emitted, centers cleared.
//  Non-power-of-two k: cnt terminates at k-1; indices >=k never read.
// TESTING
//  Reset: assert rst mid-clock -> outputs 0 immediately; pt_ready=1 first cycle after release.
//  Centers i=(30i,30i,30i), i=0..7; point (65,65,65) -> res_idx=2, res_dist=15, res_valid at E0+9.
//  Tie: c1=(10,0,0), c4=(0,10,0), others (255,255,255); point (0,0,0) -> idx=1, dist=10.
//  Extremes: all centers 0, point (255,255,255) -> idx=0, dist=765; c0=(200,200,200),
//   point (10,10,10), others 0 -> idx=1 ... expect dist 30 at idx 1; c0 dist=570 (no wrap).
//  Backpressure: res_ready=0 for 20 cycles -> res_* stable, pt_ready=0, ctr_we ignored;
//   res_ready=1 one cycle -> res_valid=0, pt_ready=1 next cycle.
//  Reset during SCAN (3rd cycle) -> res_valid never rises; centers read back 0 (next search dist 0, idx 0).

Source files
------------

// File: rtl/nearest_center_search.sv
// Flat nearest-center search: one point is scanned against k stored centers,
// one center per cycle. A registered Manhattan-distance stage feeds a running
// minimum. The winning index and distance are returned on a valid/ready port.
module nearest_center_search #(
    parameter int dim        = 3,
    parameter int data_range = 255,
    parameter int k          = 8,
    localparam int dim_size    = $clog2(data_range),
    localparam int dist_size   = $clog2(data_range * dim),
    localparam int idx_size    = $clog2(k),
    localparam int center_size = dim * dim_size
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctr_we,
    input  logic [idx_size-1:0]    ctr_waddr,
    input  logic [center_size-1:0] ctr_wdata,
    input  logic                   pt_valid,
    output logic                   pt_ready,
    input  logic [center_size-1:0] pt_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [idx_size-1:0]    res_idx,
    output logic [dist_size-1:0]   res_dist,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, OUT} state_t;

    state_t                 state_q, state_d;
    logic [center_size-1:0] ctr_q [k];
    logic [center_size-1:0] pt_q;
    logic [idx_size-1:0]    cnt_q, cnt_d;
    logic [dist_size-1:0]   d_q, dist_d;
    logic [idx_size-1:0]    i_q;
    logic                   v_q;
    logic [dist_size-1:0]   best_dist_q, best_dist_d;
    logic [idx_size-1:0]    best_idx_q, best_idx_d;
    logic                   res_valid_q;
    logic [idx_size-1:0]    res_idx_q;
    logic [dist_size-1:0]   res_dist_q;
    logic [center_size-1:0] ctr_sel;
    logic                   take;

    // Unsigned |a-b| without wrap-around.
    function automatic logic [dim_size-1:0] abs_diff(input logic [dim_size-1:0] a,
                                                     input logic [dim_size-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Zero-extend one coordinate difference to the distance width.
    function automatic logic [dist_size-1:0] widen(input logic [dim_size-1:0] a);
        return dist_size'(a);
    endfunction

    assign pt_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_idx   = res_idx_q;
    assign res_dist  = res_dist_q;

    // Distance of the point to the center currently addressed by the scan counter.
    always_comb begin
        ctr_sel = ctr_q[cnt_q];
        dist_d  = widen(abs_diff(pt_q[0*dim_size +: dim_size], ctr_sel[0*dim_size +: dim_size]))
                + widen(abs_diff(pt_q[1*dim_size +: dim_size], ctr_sel[1*dim_size +: dim_size]))
                + widen(abs_diff(pt_q[2*dim_size +: dim_size], ctr_sel[2*dim_size +: dim_size]));
    end

    // Running minimum; index 0 always seeds it, strict less-than keeps the lowest index on ties.
    always_comb begin
        take        = v_q && ((i_q == '0) || (d_q < best_dist_q));
        best_dist_d = take ? d_q : best_dist_q;
        best_idx_d  = take ? i_q : best_idx_q;
    end

    // Next-state logic for the IDLE->SCAN->DRAIN->OUT sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE:  if (pt_valid && pt_ready) state_d = SCAN;
            SCAN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == idx_size'(k - 1)) state_d = DRAIN;
            end
            DRAIN: state_d = OUT;
            OUT:   if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state, result port and center storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            v_q         <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_dist_q  <= '0;
            for (int i = 0; i < k; i++) ctr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= (state_q == SCAN);
            if (state_q == IDLE && ctr_we && (int'(ctr_waddr) < k))
                ctr_q[ctr_waddr] <= ctr_wdata;
            if (state_q == DRAIN) begin
                res_valid_q <= 1'b1;
                res_idx_q   <= best_idx_d;
                res_dist_q  <= best_dist_d;
            end else if (state_q == OUT && res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // Datapath registers: latched point, distance stage and running best.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && pt_valid && pt_ready) pt_q <= pt_data;
        d_q         <= dist_d;
        i_q         <= cnt_q;
        best_dist_q <= best_dist_d;
        best_idx_q  <= best_idx_d;
    end

endmodule

// File: tb/tb_nearest_center_search.sv
// Randomized and directed bench for nearest_center_search against a loop-based reference.
module tb_nearest_center_search;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctr_we = 1'b0;
    logic [2:0]  ctr_waddr = '0;
    logic [23:0] ctr_wdata = '0;
    logic        pt_valid = 1'b0;
    logic        pt_ready;
    logic [23:0] pt_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [2:0]  res_idx;
    logic [9:0]  res_dist;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int mx[8], my[8], mz[8];

    nearest_center_search dut (
        .clk(clk), .rst(rst), .ctr_we(ctr_we), .ctr_waddr(ctr_waddr), .ctr_wdata(ctr_wdata),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
        .res_dist(res_dist), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: exhaustive nearest search, first minimum wins.
    function automatic void nearest(input int px, input int py, input int pz,
                                    output int bi, output int bd);
        bi = 0;
        bd = 1 << 30;
        for (int i = 0; i < 8; i++) begin
            int d;
            d = iabs(px - mx[i]) + iabs(py - my[i]) + iabs(pz - mz[i]);
            if (d < bd) begin
                bd = d;
                bi = i;
            end
        end
    endfunction

    task automatic wr_ctr(input int i, input int x, input int y, input int z);
        @(negedge clk);
        ctr_we    = 1'b1;
        ctr_waddr = i[2:0];
        ctr_wdata = {z[7:0], y[7:0], x[7:0]};
        @(posedge clk);
        #1 ctr_we = 1'b0;
        mx[i] = x; my[i] = y; mz[i] = z;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            mx[i] = 0; my[i] = 0; mz[i] = 0;
        end
    endtask

    // One search; optionally hold the result for `hold` cycles while poking center writes.
    task automatic search(input string tag, input int px, input int py, input int pz,
                          input int hold);
        int ei, ed, n;
        nearest(px, py, pz, ei, ed);
        @(negedge clk);
        pt_valid = 1'b1;
        pt_data  = {pz[7:0], py[7:0], px[7:0]};
        @(posedge clk);
        #1 pt_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, ".lat"}, n, 9);
        chk({tag, ".idx"}, res_idx, ei);
        chk({tag, ".dist"}, res_dist, ed);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            ctr_we    = 1'b1;
            ctr_waddr = 3'(c);
            ctr_wdata = 24'hFFFFFF;
            @(posedge clk);
            #1;
            chk({tag, ".hold_v"}, res_valid, 1);
            chk({tag, ".hold_idx"}, res_idx, ei);
            chk({tag, ".hold_dist"}, res_dist, ed);
            chk({tag, ".hold_rdy"}, pt_ready, 0);
        end
        @(negedge clk);
        ctr_we    = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk({tag, ".v_clr"}, res_valid, 0);
        chk({tag, ".rdy"}, pt_ready, 1);
        chk({tag, ".keep_idx"}, res_idx, ei);
    endtask

    initial begin
        int seen;
        clear_model();

        // Reset state
        #1;
        chk("rst.valid", res_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.ready", pt_ready, 0);
        chk("rst.idx", res_idx, 0);
        chk("rst.dist", res_dist, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("rst.ready_after", pt_ready, 1);

        // Linear centers
        for (int i = 0; i < 8; i++) wr_ctr(i, 30 * i, 30 * i, 30 * i);
        search("lin", 65, 65, 65, 0);

        // Tie resolves to the lower index
        for (int i = 0; i < 8; i++) wr_ctr(i, 255, 255, 255);
        wr_ctr(1, 10, 0, 0);
        wr_ctr(4, 0, 10, 0);
        search("tie", 0, 0, 0, 0);

        // Extremes
        for (int i = 0; i < 8; i++) wr_ctr(i, 0, 0, 0);
        search("max", 255, 255, 255, 0);
        wr_ctr(0, 200, 200, 200);
        search("nowrap", 10, 10, 10, 0);

        // Backpressure with ignored center writes, then confirm centers untouched
        search("bp", 100, 20, 7, 20);
        search("bp_after", 200, 200, 200, 0);

        // Reset in the third scan cycle
        for (int i = 0; i < 8; i++) wr_ctr(i, 50 + i, 60, 70);
        @(negedge clk);
        pt_valid = 1'b1;
        pt_data  = {8'd1, 8'd2, 8'd3};
        @(posedge clk);
        #1 pt_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.valid", res_valid, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.ready", pt_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1 if (res_valid) seen = 1;
        end
        chk("midrst.no_result", seen, 0);
        search("midrst.zero", 0, 0, 0, 0);
        search("midrst.pt", 17, 99, 3, 0);

        // Randomized centers and points, narrow ranges in odd rounds to provoke ties
        for (int r = 0; r < 25; r++) begin
            int lim;
            lim = (r % 2 == 1) ? 8 : 255;
            for (int w = 0; w < 4; w++)
                wr_ctr($urandom_range(7), $urandom_range(lim), $urandom_range(lim),
                       $urandom_range(lim));
            search("rnd", $urandom_range(lim), $urandom_range(lim), $urandom_range(lim), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
